// File: rtl/nios2_debug_ocimem_if.sv
// Shared constants for the ocimem sequencer; the bus interface is in nios2_debug_ocimem_seq_if.sv.
package nios2_debug_ocimem_pkg;
    localparam int JDO_W = 38;
endpackage

// File: rtl/nios2_debug_ocimem_seq_if.sv
// Bus between the debug-slave wrapper / debug RAM and the ocimem sequencer.
// master: wrapper + RAM side, slave: the sequencer.
interface nios2_debug_ocimem_seq_if #(
    parameter int ADDR_W = 8
);
    logic [37:0]       jdo;
    logic              take_action_ocimem_a;
    logic              take_action_ocimem_b;
    logic              take_no_action_ocimem_a;
    logic              err_clr;
    logic [ADDR_W-1:0] ram_addr;
    logic [31:0]       ram_wdata;
    logic              ram_we;
    logic              ram_re;
    logic [31:0]       ram_rdata;
    logic [31:0]       MonDReg;
    logic              busy;
    logic              ovr_err;

    modport master (
        output jdo, take_action_ocimem_a, take_action_ocimem_b, take_no_action_ocimem_a,
               err_clr, ram_rdata,
        input  ram_addr, ram_wdata, ram_we, ram_re, MonDReg, busy, ovr_err
    );

    modport slave (
        input  jdo, take_action_ocimem_a, take_action_ocimem_b, take_no_action_ocimem_a,
               err_clr, ram_rdata,
        output ram_addr, ram_wdata, ram_we, ram_re, MonDReg, busy, ovr_err
    );
endinterface

// File: rtl/nios2_debug_ocimem_seq.sv
// Sysclk-domain sequencer for single-word debug RAM reads/writes behind the
// Nios II debug-slave wrapper, with auto-incrementing address and MonDReg return.
//
// state    | meaning
// IDLE     | waiting for an ocimem strobe
// WRITE    | ram_we pulse at MonAReg, then increment
// RD_ISSUE | ram_re pulse at MonAReg
// RD_WAIT  | count out RAM latency, capture ram_rdata, then increment
module nios2_debug_ocimem_seq #(
    parameter int ADDR_W = 8,
    parameter int RD_LAT = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    nios2_debug_ocimem_seq_if.slave  bus
);
    localparam int LAT_W = $clog2(RD_LAT + 1);
    localparam logic [LAT_W-1:0] LAT_INIT = LAT_W'(RD_LAT - 1);

    typedef enum logic [1:0] {IDLE, WRITE, RD_ISSUE, RD_WAIT} state_t;

    state_t            state;
    logic [ADDR_W-1:0] mon_a_reg;
    logic [31:0]       mon_d_reg;
    logic [31:0]       wdata;
    logic [LAT_W-1:0]  lat_cnt;
    logic              we_q;
    logic              re_q;
    logic              busy_q;
    logic              ovr_q;

    logic [2:0] stb;
    logic       any_stb;
    logic       multi_stb;
    logic       drop;
    logic       unused_jdo;

    assign stb       = {bus.take_action_ocimem_a, bus.take_action_ocimem_b,
                        bus.take_no_action_ocimem_a};
    assign any_stb   = |stb;
    assign multi_stb = (stb[2] & (stb[1] | stb[0])) | (stb[1] & stb[0]);
    // Outside IDLE every strobe is lost; in IDLE only the losers of the priority pick are.
    assign drop      = (state != IDLE) ? any_stb : multi_stb;
    assign unused_jdo = ^{bus.jdo[37:36], bus.jdo[2:0]};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            mon_a_reg <= '0;
            mon_d_reg <= '0;
            wdata     <= '0;
            lat_cnt   <= '0;
            we_q      <= 1'b0;
            re_q      <= 1'b0;
            busy_q    <= 1'b0;
            ovr_q     <= 1'b0;
        end else begin
            we_q <= 1'b0;
            re_q <= 1'b0;

            if (drop) begin
                ovr_q <= 1'b1;
            end else if (bus.err_clr) begin
                ovr_q <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (stb[2]) begin
                        mon_a_reg <= bus.jdo[17 +: ADDR_W];
                        if (bus.jdo[35]) begin
                            state  <= RD_ISSUE;
                            re_q   <= 1'b1;
                            busy_q <= 1'b1;
                        end
                    end else if (stb[1]) begin
                        wdata  <= bus.jdo[34:3];
                        state  <= WRITE;
                        we_q   <= 1'b1;
                        busy_q <= 1'b1;
                    end else if (stb[0]) begin
                        state  <= RD_ISSUE;
                        re_q   <= 1'b1;
                        busy_q <= 1'b1;
                    end
                end
                WRITE: begin
                    mon_a_reg <= mon_a_reg + ADDR_W'(1);
                    state     <= IDLE;
                    busy_q    <= 1'b0;
                end
                RD_ISSUE: begin
                    lat_cnt <= LAT_INIT;
                    state   <= RD_WAIT;
                end
                RD_WAIT: begin
                    if (lat_cnt != '0) begin
                        lat_cnt <= lat_cnt - LAT_W'(1);
                    end else begin
                        mon_d_reg <= bus.ram_rdata;
                        mon_a_reg <= mon_a_reg + ADDR_W'(1);
                        state     <= IDLE;
                        busy_q    <= 1'b0;
                    end
                end
                default: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.ram_addr  = mon_a_reg;
    assign bus.ram_wdata = wdata;
    assign bus.ram_we    = we_q;
    assign bus.ram_re    = re_q;
    assign bus.MonDReg   = mon_d_reg;
    assign bus.busy      = busy_q;
    assign bus.ovr_err   = ovr_q;
endmodule

// File: doc/nios2_debug_ocimem_seq.md
Name: nios2_debug_ocimem_seq

Overview:
Sysclk-domain sequencer directly downstream of the Nios II debug-slave wrapper. It consumes the wrapper's jdo bus and its ocimem action strobes. It performs single-word reads and writes to the on-chip debug RAM through an auto-incrementing address register. It returns read data on MonDReg, which feeds back into the debug-slave wrapper's MonDReg input for the next JTAG scan.

Parameters:
ADDR_W, 8, debug RAM word-address width (RAM depth 2^ADDR_W words of 32 bits)
RD_LAT, 1, RAM read latency in clocks from ram_re cycle to valid ram_rdata; legal 1..4

Ports:
clk  in  1  system clock; all logic rising-edge
reset  in  1  asynchronous, active-high reset
jdo  in  38  JTAG data from the debug slave, stable while a strobe is high
take_action_ocimem_a  in  1  1-cycle strobe: load address, optionally start a read
take_action_ocimem_b  in  1  1-cycle strobe: write jdo[34:3] at current address
take_no_action_ocimem_a  in  1  1-cycle strobe: read at current address
err_clr  in  1  clears ovr_err
ram_addr  out  ADDR_W  debug RAM address
ram_wdata  out  32  debug RAM write data
ram_we  out  1  write enable, 1 cycle per write
ram_re  out  1  read enable, 1 cycle per read
ram_rdata  in  32  debug RAM read data
MonDReg  out  32  last read data, to debug slave wrapper
busy  out  1  high while a command is in progress
ovr_err  out  1  sticky: a strobe was dropped

Behaviour:
- Reset (async assert, sync-safe deassert by the system):
  - MonAReg=0, MonDReg=0, ram_we=0, ram_re=0, ram_wdata=0, busy=0, ovr_err=0, state=IDLE.
  - Reset mid-operation aborts the command immediately. No partial write is ever issued after reset.
- ram_addr is always MonAReg.
- Registers: MonAReg[ADDR_W-1:0], MonDReg[31:0], wdata[31:0], lat_cnt (width ceil(log2(RD_LAT+1))).
- States: IDLE, WRITE, RD_ISSUE, RD_WAIT.
- IDLE, strobe sampled at edge ending cycle T; priority a > b > no_action_a:
  - take_action_ocimem_a:
    - MonAReg <= jdo[17+ADDR_W-1:17].
    - If jdo[35]=1, go to RD_ISSUE; else stay IDLE (busy stays 0).
  - take_action_ocimem_b: wdata <= jdo[34:3]; go to WRITE.
  - take_no_action_ocimem_a: go to RD_ISSUE.
- WRITE (cycle T+1): ram_we=1, ram_wdata=wdata, busy=1. At the edge, MonAReg <= MonAReg+1 and state goes to IDLE.
- RD_ISSUE (cycle T+1): ram_re=1, busy=1. lat_cnt <= RD_LAT-1; go to RD_WAIT.
- RD_WAIT: busy=1.
  - If lat_cnt != 0, decrement lat_cnt.
  - If lat_cnt = 0: MonDReg <= ram_rdata, MonAReg <= MonAReg+1, go to IDLE.
  - Read latency: MonDReg updated and busy=0 from cycle T+2+RD_LAT.
- ram_we and ram_re are registered outputs, never both high, each high exactly 1 cycle per command.
- Address arithmetic is modulo 2^ADDR_W: 2^ADDR_W-1 increments to 0 with no flag.
- MonDReg changes only on read capture or reset; writes never modify it.
- Dropped strobes set ovr_err. Each of the following is ignored and sets ovr_err:
  - any strobe while busy=1 (including the cycle in which a command completes);
  - any lower-priority strobe in the same cycle as an accepted one.
- ovr_err: err_clr clears it. If a set and err_clr occur in the same cycle, the set wins.
- jdo is sampled only in the cycle a strobe is accepted.
- jdo bits [37:36], [2:0] and the unused address bits are ignored.

Test Plan:
1. Reset released, no strobes -> MonDReg=0x00000000, ram_addr=0, busy=0, ovr_err=0; assert reset during RD_WAIT -> all outputs at reset values the same cycle, ram_re never re-pulses.
2. take_action_ocimem_a with jdo[24:17]=0x10, jdo[35]=0; then take_action_ocimem_b with jdo[34:3]=0xDEADBEEF -> one ram_we pulse at addr 0x10 with wdata 0xDEADBEEF; ram_addr becomes 0x11.
3. take_action_ocimem_a with addr 0x10, jdo[35]=1, RAM preloaded 0xDEADBEEF, RD_LAT=1 -> ram_re at T+1 addr 0x10; MonDReg=0xDEADBEEF and busy=0 at T+3; ram_addr=0x11. Repeat with RD_LAT=3 -> MonDReg valid at T+5.
4. Load addr 0xFF, two take_no_action_ocimem_a reads -> reads of 0xFF then 0x00; final ram_addr=0x01.
5. take_action_ocimem_b and take_no_action_ocimem_a asserted in the same cycle -> only the write is performed, ovr_err=1; strobe during busy -> no RAM access, ovr_err stays 1; err_clr -> ovr_err=0; err_clr coincident with a new drop -> ovr_err=1.
